// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, drives a 1-cycle synchronous imem, loads IF/ID.
// Handles stall, flush, branch redirect and a sticky HALT opcode.
module instr_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [3:0]         if_id_opcode,
    output logic               halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } mode_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    mode_t             mode;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend_valid;
    logic              halt_hit;

    assign halt_hit = pend_valid &&
                      (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

    assign if_id_opcode = if_id_instr[INSTR_W-1 -: 4];

    // Re-reading pend_pc keeps imem_rdata valid while held.
    always_comb begin
        imem_addr = fetch_pc;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else if (stall || mode == HALT) begin
            imem_addr = pend_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= RUN;
            fetch_pc    <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            mode        <= RUN;
            halted      <= 1'b0;
            if_id_valid <= 1'b0;
            pend_valid  <= 1'b1;
            pend_pc     <= redirect_pc;
            fetch_pc    <= redirect_pc + PC_STEP;
        end else if (mode == HALT) begin
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_pc     <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_STEP;
        end else if (!stall) begin
            if_id_valid <= pend_valid;
            if_id_instr <= imem_rdata;
            if_id_pc    <= pend_pc;
            if (halt_hit) begin
                mode       <= HALT;
                halted     <= 1'b1;
                pend_valid <= 1'b0;
            end else begin
                pend_valid <= 1'b1;
                pend_pc    <= fetch_pc;
                fetch_pc   <= fetch_pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: 32-bit instance plus an
// 8-bit instance that exercises PC wrap-around.
module tb_instr_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [3:0]  if_id_opcode;
    logic        halted;

    logic        rst2 = 1'b1;
    logic        stall2 = 1'b0;
    logic        flush2 = 1'b0;
    logic        rv2 = 1'b0;
    logic [7:0]  rpc2 = '0;
    logic [7:0]  addr2;
    logic [31:0] rdata2 = '0;
    logic        v2;
    logic [31:0] instr2;
    logic [7:0]  pc2;
    logic [3:0]  op2;
    logic        h2;

    instr_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_opcode(if_id_opcode),
        .halted(halted)
    );

    instr_fetch_stage #(
        .ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hFF)
    ) dut2 (
        .clk(clk), .rst(rst2), .stall(stall2), .flush(flush2),
        .redirect_valid(rv2), .redirect_pc(rpc2),
        .imem_addr(addr2), .imem_rdata(rdata2),
        .if_id_valid(v2), .if_id_instr(instr2),
        .if_id_pc(pc2), .if_id_opcode(op2),
        .halted(h2)
    );

    bit          halt_en = 1'b0;
    logic [31:0] halt_addr = 32'd3;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return 32'hF000_0000;
        return 32'h1000_0000 + a;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);
    always @(posedge clk) rdata2 <= 32'h1000_0000 + {24'h0, addr2};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t       q1[$];
    logic [7:0] q2[$];

    task automatic push1(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        q1.push_back(e);
    endtask

    logic        stall_q = 1'b0;
    logic [31:0] last_pc = '0;
    always @(posedge clk) stall_q <= stall;

    always @(negedge clk) begin
        if (if_id_valid === 1'b1) begin
            if (stall_q) begin
                chk("hold_pc", if_id_pc, last_pc);
            end else if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected: pc %0h with empty queue",
                         if_id_pc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("pc", if_id_pc, e.pc);
                chk("instr", if_id_instr, e.instr);
                chk("opcode", if_id_opcode, e.instr[31:28]);
                last_pc = if_id_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (v2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected2: pc %0h with empty queue", pc2);
            end else begin
                logic [7:0] e;
                e = q2.pop_front();
                chk("pc8", pc2, e);
                chk("instr8", instr2, 32'h1000_0000 + {24'h0, e});
            end
        end
    end

    task automatic wait_pc(input logic [31:0] t, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (if_id_valid === 1'b1 && if_id_pc == t) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL %s: timeout, pc %0h required", nm, t);
        end
    endtask

    task automatic run_main();
        halt_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", imem_addr, 0);
        for (int i = 0; i < 10; i++) push1(i);
        rst = 1'b0;

        wait_pc(5, "wait5");
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0;

        wait_pc(9, "wait9");
        for (int i = 'h40; i < 'h45; i++) push1(i);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1 chk("redir_addr", imem_addr, 32'h40);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_bubble", if_id_valid, 0);
        wait_pc(32'h44, "wait44");

        rst = 1'b1;
        halt_en = 1'b1;
        halt_addr = 32'd3;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) push1(i);
        rst = 1'b0;
        wait_pc(3, "wait_halt");
        chk("halt_set", halted, 1);
        chk("halt_op", if_id_opcode, 4'hF);
        repeat (4) begin
            @(negedge clk);
            chk("halt_valid", if_id_valid, 0);
            chk("halt_flag", halted, 1);
        end
        for (int i = 'h10; i < 'h13; i++) push1(i);
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("halt_exit", halted, 0);
        wait_pc(32'h12, "wait12");

        push1(32'h20);
        push1(32'h21);
        stall = 1'b1;
        flush = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        chk("sfr_bubble", if_id_valid, 0);
        wait_pc(32'h21, "wait21");
        push1(32'h24);
        push1(32'h25);
        flush = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        chk("flush_b1", if_id_valid, 0);
        @(negedge clk);
        chk("flush_b2", if_id_valid, 0);
        wait_pc(32'h25, "wait25");

        rst = 1'b1;
        halt_addr = 32'd1;
        repeat (2) @(negedge clk);
        push1(0);
        push1(1);
        rst = 1'b0;
        wait_pc(1, "wait_halt1");
        chk("halt1_set", halted, 1);
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h30;
        #1 chk("rst_redir_addr", imem_addr, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rst_redir_halted", halted, 0);
        chk("rst_redir_valid", if_id_valid, 0);
        halt_en = 1'b0;
        for (int i = 0; i < 3; i++) push1(i);
        @(negedge clk);
        rst = 1'b0;
        wait_pc(2, "wait_restart");
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_wrap();
        bit hit = 1'b0;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_addr", addr2, 8'hFF);
        q2.push_back(8'hFF);
        q2.push_back(8'h00);
        q2.push_back(8'h01);
        q2.push_back(8'h02);
        rst2 = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (v2 === 1'b1 && pc2 == 8'h02) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL wrap: timeout, pc 02 required");
        end
        rst2 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        fork
            run_main();
            run_wrap();
        join
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
